// File: rtl/mic_delay_ram_if.sv
// Write/read bundle for mic_delay_ram: channel-ordered sample writes, delayed reads,
// status pulses. The master side drives the stimulus; the slave side is the RAM block.
interface mic_delay_ram_if #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 512,
    parameter int CHANNELS = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CHANNELS);

    logic             flush;
    logic             wr_en;
    logic [CW-1:0]    wr_ch;
    logic [WIDTH-1:0] din;
    logic             frame_done;
    logic             seq_err;
    logic [AW-1:0]    fill;
    logic             rd_en;
    logic [CW-1:0]    rd_ch;
    logic [AW-1:0]    rd_delay;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_miss;

    modport master (
        output flush, wr_en, wr_ch, din, rd_en, rd_ch, rd_delay,
        input  frame_done, seq_err, fill, dout, dout_valid, dout_miss
    );

    modport slave (
        input  flush, wr_en, wr_ch, din, rd_en, rd_ch, rd_delay,
        output frame_done, seq_err, fill, dout, dout_valid, dout_miss
    );
endinterface

// File: rtl/mic_delay_ram.sv
// Multi-channel circular sample history: channel-ordered frame writes into one
// CHANNELS x DEPTH memory, per-channel reads at a frame delay with a 3-register pipeline.
module mic_delay_ram #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 512,
    parameter int CHANNELS = 8
) (
    input  logic           clk,
    input  logic           reset,
    mic_delay_ram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CHANNELS);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] CH_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CH_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] FILL_MAX = {AW{1'b1}};

    logic [WIDTH-1:0] mem [CHANNELS*DEPTH];

    logic [AW-1:0]    wptr_q,       wptr_d;
    logic [CW-1:0]    exp_ch_q,     exp_ch_d;
    logic [AW-1:0]    fill_q,       fill_d;
    logic             frame_done_q, frame_done_d;
    logic             seq_err_q,    seq_err_d;
    logic [CW+AW-1:0] rd_addr_q,    rd_addr_d;
    logic             rd_v1_q,      rd_v1_d;
    logic             rd_miss1_q,   rd_miss1_d;
    logic             rd_v2_q,      rd_v2_d;
    logic             rd_miss2_q,   rd_miss2_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_miss_q,  dout_miss_d;
    logic [WIDTH-1:0] ram_rd_q;
    logic             mem_we_s;
    logic [CW+AW-1:0] mem_waddr_s;
    logic [AW-1:0]    rd_ptr_s;

    // Write sequencing: channel order check, frame commit, fill tracking, flush.
    always_comb begin
        wptr_d       = wptr_q;
        exp_ch_d     = exp_ch_q;
        fill_d       = fill_q;
        frame_done_d = 1'b0;
        seq_err_d    = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = {bus.wr_ch, wptr_q};
        if (bus.flush) begin
            wptr_d   = PTR_ZERO;
            exp_ch_d = CH_ZERO;
            fill_d   = PTR_ZERO;
        end else if (bus.wr_en) begin
            if (bus.wr_ch == exp_ch_q) begin
                mem_we_s = 1'b1;
                if (bus.wr_ch == LAST_CH) begin
                    wptr_d       = wptr_q + PTR_ONE;
                    exp_ch_d     = CH_ZERO;
                    frame_done_d = 1'b1;
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + PTR_ONE;
                    end else begin
                        fill_d = fill_q;
                    end
                end else begin
                    exp_ch_d = exp_ch_q + CH_ONE;
                end
            end else begin
                // A stray channel 0 restarts the frame in place; anything else is dropped.
                seq_err_d = 1'b1;
                if (bus.wr_ch == CH_ZERO) begin
                    mem_we_s = 1'b1;
                    exp_ch_d = CH_ONE;
                end else begin
                    mem_we_s = 1'b0;
                    exp_ch_d = CH_ZERO;
                end
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read pipeline: address/miss capture, RAM register, output register.
    always_comb begin
        rd_ptr_s     = wptr_q - PTR_ONE - bus.rd_delay;
        rd_addr_d    = {bus.rd_ch, rd_ptr_s};
        rd_v1_d      = bus.rd_en;
        rd_miss1_d   = bus.rd_en & (bus.rd_delay >= fill_q);
        rd_v2_d      = rd_v1_q;
        rd_miss2_d   = rd_miss1_q;
        dout_valid_d = rd_v2_q;
        dout_miss_d  = rd_v2_q & rd_miss2_q;
        if (rd_v2_q) begin
            if (rd_miss2_q) begin
                dout_d = {WIDTH{1'b0}};
            end else begin
                dout_d = ram_rd_q;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= PTR_ZERO;
            exp_ch_q     <= CH_ZERO;
            fill_q       <= PTR_ZERO;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            rd_addr_q    <= {(CW+AW){1'b0}};
            rd_v1_q      <= 1'b0;
            rd_miss1_q   <= 1'b0;
            rd_v2_q      <= 1'b0;
            rd_miss2_q   <= 1'b0;
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            dout_miss_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            exp_ch_q     <= exp_ch_d;
            fill_q       <= fill_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
            rd_addr_q    <= rd_addr_d;
            rd_v1_q      <= rd_v1_d;
            rd_miss1_q   <= rd_miss1_d;
            rd_v2_q      <= rd_v2_d;
            rd_miss2_q   <= rd_miss2_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_miss_q  <= dout_miss_d;
        end
    end

    // Simple-dual-port storage, left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= bus.din;
        end
        ram_rd_q <= mem[rd_addr_q];
    end

    assign bus.frame_done = frame_done_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.fill       = fill_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_miss  = dout_miss_q;
endmodule

// File: tb/tb_mic_delay_ram.sv
// Bench for mic_delay_ram: directed vector table and hand sequences plus random traffic,
// all checked every cycle against a frame-history model built from queues.
module tb_mic_delay_ram;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int CHANNELS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mic_delay_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) bus ();

    mic_delay_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [2:0]  dly;
        bit          miss;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [12];
    int checks   = 0;
    int failures = 0;

    // Model: committed frames per channel, newest first, plus the frame under construction.
    logic [15:0] hist [CHANNELS][$];
    logic [15:0] pend [CHANNELS];
    int          m_exp     = 0;
    int          m_commits = 0;
    bit          pv [3];
    bit          pm [3];
    logic [15:0] pd [3];
    logic [15:0] e_dout = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_fill();
        return (m_commits > DEPTH - 1) ? DEPTH - 1 : m_commits;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++) hist[c].delete();
        m_exp     = 0;
        m_commits = 0;
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_ch    = 2'd0;
        bus.din      = 16'h0000;
        bus.rd_en    = 1'b0;
        bus.rd_ch    = 2'd0;
        bus.rd_delay = 3'd0;
    endtask

    // One clock: predict from pre-edge model state, advance, then compare every output.
    task automatic cycle();
        bit          rv, rm, fd, se;
        logic [15:0] rdat;
        rv = bus.rd_en; rm = 1'b0; rdat = 16'h0000; fd = 1'b0; se = 1'b0;
        if (bus.rd_en) begin
            if (int'(bus.rd_delay) >= m_fill()) rm = 1'b1;
            else rdat = hist[bus.rd_ch][bus.rd_delay];
        end
        if (bus.flush) begin
            model_clear();
        end else if (bus.wr_en) begin
            if (int'(bus.wr_ch) == m_exp) begin
                pend[bus.wr_ch] = bus.din;
                if (m_exp == CHANNELS - 1) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        hist[c].push_front(pend[c]);
                        if (hist[c].size() > DEPTH) void'(hist[c].pop_back());
                    end
                    m_commits++;
                    m_exp = 0;
                    fd    = 1'b1;
                end else begin
                    m_exp++;
                end
            end else begin
                se = 1'b1;
                if (bus.wr_ch == 2'd0) begin
                    pend[0] = bus.din;
                    m_exp   = 1;
                end else begin
                    m_exp = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        pv[2] = pv[1]; pm[2] = pm[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pm[1] = pm[0]; pd[1] = pd[0];
        pv[0] = rv;    pm[0] = rm;    pd[0] = rdat;
        if (pv[2]) e_dout = pm[2] ? 16'h0000 : pd[2];
        check("frame_done", bus.frame_done, fd);
        check("seq_err", bus.seq_err, se);
        check("fill", bus.fill, m_fill());
        check("dout_valid", bus.dout_valid, pv[2]);
        check("dout_miss", bus.dout_miss, pv[2] & pm[2]);
        check("dout", bus.dout, e_dout);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        model_clear();
        for (int s = 0; s < 3; s++) begin pv[s] = 1'b0; pm[s] = 1'b0; pd[s] = 16'h0000; end
        e_dout = 16'h0000;
        check("rst_dout", bus.dout, 16'h0000);
        check("rst_dout_valid", bus.dout_valid, 1'b0);
        check("rst_dout_miss", bus.dout_miss, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_seq_err", bus.seq_err, 1'b0);
        check("rst_fill", bus.fill, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'(ch);
        bus.din   = d;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    task automatic read_one(input string name, input int ch, input int dly,
                            input bit miss, input logic [15:0] data);
        bus.rd_en    = 1'b1;
        bus.rd_ch    = 2'(ch);
        bus.rd_delay = 3'(dly);
        cycle();
        bus.rd_en = 1'b0;
        cycle();
        cycle();
        check({name, "_valid"}, bus.dout_valid, 1'b1);
        check({name, "_miss"}, bus.dout_miss, miss);
        check({name, "_dout"}, bus.dout, data);
    endtask

    // Back-to-back reads from the vector table; results appear two cycles after issue.
    task automatic run_vecs(input int first, input int n);
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                bus.rd_en    = 1'b1;
                bus.rd_ch    = vecs[first + k].ch;
                bus.rd_delay = vecs[first + k].dly;
            end else begin
                bus.rd_en = 1'b0;
            end
            cycle();
            if (k >= 2) begin
                check($sformatf("vec%0d_valid", first + k - 2), bus.dout_valid, 1'b1);
                check($sformatf("vec%0d_miss", first + k - 2), bus.dout_miss, vecs[first + k - 2].miss);
                check($sformatf("vec%0d_dout", first + k - 2), bus.dout, vecs[first + k - 2].data);
            end
        end
    endtask

    initial begin
        int n_fd;
        vecs[0] = '{2'd0, 3'd0, 1'b1, 16'h0000};
        vecs[1] = '{2'd2, 3'd0, 1'b0, 16'h0202};
        vecs[2] = '{2'd1, 3'd2, 1'b0, 16'h0001};
        vecs[3] = '{2'd0, 3'd3, 1'b1, 16'h0000};
        for (int d = 0; d < 7; d++) vecs[4 + d] = '{2'd3, 3'(d), 1'b0, {8'(11 - d), 8'h03}};
        vecs[11] = '{2'd3, 3'd7, 1'b1, 16'h0000};

        idle();
        #1;
        apply_reset();

        // 1: read from an empty history misses
        run_vecs(0, 1);

        // 2: three frames, then delayed reads
        n_fd = 0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr(c, {8'(f), 8'(c)});
                if (bus.frame_done) n_fd++;
            end
        end
        check("t2_frame_done_count", n_fd, 3);
        check("t2_fill", bus.fill, 3'd3);
        run_vecs(1, 3);

        // 3: twelve frames saturate fill; sweep all delays back-to-back
        for (int f = 0; f < 12; f++)
            for (int c = 0; c < CHANNELS; c++) wr(c, {8'(f), 8'(c)});
        check("t3_fill_sat", bus.fill, 3'd7);
        run_vecs(4, 8);

        // 4a: skipped channel drops the sample and restarts the frame
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("t4_flush_fill", bus.fill, 3'd0);
        wr(0, 16'h4000);
        wr(1, 16'h4001);
        wr(3, 16'h4003);
        check("t4a_seq_err", bus.seq_err, 1'b1);
        check("t4a_fill_hold", bus.fill, 3'd0);
        for (int c = 0; c < CHANNELS; c++) wr(c, 16'h4A00 + 16'(c));
        check("t4a_fill", bus.fill, 3'd1);

        // 4b: early channel 0 abandons the partial frame
        wr(0, 16'h4B00);
        wr(1, 16'h4B01);
        wr(0, 16'h4C00);
        check("t4b_seq_err", bus.seq_err, 1'b1);
        wr(1, 16'h4C01);
        wr(2, 16'h4C02);
        wr(3, 16'h4C03);
        check("t4b_frame_done", bus.frame_done, 1'b1);
        check("t4b_fill", bus.fill, 3'd2);
        read_one("t4b_rd0", 0, 0, 1'b0, 16'h4C00);
        read_one("t4b_rd1", 0, 1, 1'b0, 16'h4A00);

        // 5: read in the commit cycle sees the previous frame
        wr(0, 16'h5D00);
        wr(1, 16'h5D01);
        wr(2, 16'h5D02);
        bus.rd_en = 1'b1; bus.rd_ch = 2'd1; bus.rd_delay = 3'd0;
        wr(3, 16'h5D03);
        bus.rd_en = 1'b0;
        check("t5_fill_commit", bus.fill, 3'd3);
        cycle();
        cycle();
        check("t5_same_cycle_dout", bus.dout, 16'h4C01);
        check("t5_same_cycle_miss", bus.dout_miss, 1'b0);

        // 5: flush with a read in flight and a write in the flush cycle
        bus.rd_en = 1'b1; bus.rd_ch = 2'd2; bus.rd_delay = 3'd0;
        wr(0, 16'h6E00);
        bus.rd_en = 1'b0;
        bus.flush = 1'b1;
        wr(1, 16'h6E01);
        bus.flush = 1'b0;
        check("t5_flush_fill", bus.fill, 3'd0);
        cycle();
        check("t5_inflight_valid", bus.dout_valid, 1'b1);
        check("t5_inflight_miss", bus.dout_miss, 1'b0);
        check("t5_inflight_dout", bus.dout, 16'h5D02);
        read_one("t5_post_flush", 0, 0, 1'b1, 16'h0000);
        wr(1, 16'h7001);
        check("t5_flush_exp_ch", bus.seq_err, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.flush    = ($urandom_range(0, 49) == 0);
            bus.wr_en    = ($urandom_range(0, 3) != 0);
            bus.wr_ch    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_exp);
            bus.din      = 16'($urandom);
            bus.rd_en    = 1'($urandom_range(0, 1));
            bus.rd_ch    = 2'($urandom_range(0, 3));
            bus.rd_delay = 3'($urandom_range(0, 7));
            cycle();
        end
        idle();

        // 6: reset with two reads in flight
        bus.rd_en = 1'b1; bus.rd_ch = 2'd0; bus.rd_delay = 3'd0;
        cycle();
        bus.rd_ch = 2'd1;
        cycle();
        idle();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t6_no_valid", bus.dout_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mic_delay_ram.md
# mic_delay_ram

Parametrised multi-channel circular sample history RAM for the microphone-array front end. Time-multiplexed channel samples are stored per frame into one inferred simple-dual-port memory of CHANNELS×DEPTH words. Any channel can be read back at an arbitrary frame delay, one read per cycle, for delay-and-sum beamforming. The block replaces fixed 512×16 single-channel RAM instances: width, depth and channel count become parameters, and it adds frame sequencing, fill tracking and underflow detection.

## Interface
- WIDTH, 16, sample width in bits (signed two's complement, passed through unmodified)
- DEPTH, 512, frames of history per channel; power of two, ≥4
- CHANNELS, 8, channels per frame; power of two, ≥2
- AW, log2(DEPTH), derived, not overridden
- CW, log2(CHANNELS), derived, not overridden

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous clear of pointers and fill
- wr_en  in  1  write strobe
- wr_ch  in  CW  channel index of din
- din  in  WIDTH  sample
- frame_done  out  1  one-cycle pulse, frame committed
- seq_err  out  1  one-cycle pulse, channel-order violation
- fill  out  AW  committed frames readable, saturates at DEPTH-1
- rd_en  in  1  read request
- rd_ch  in  CW  channel to read
- rd_delay  in  AW  0 = most recent committed frame
- dout  out  WIDTH  read data
- dout_valid  out  1  dout qualifies a read issued 2 cycles earlier
- dout_miss  out  1  requested frame not available; dout forced 0

## Operation
- State: wptr (AW), exp_ch (CW), fill (AW), memory array (not reset, no init contents).
- Write, wr_en=1 and wr_ch==exp_ch:
  - mem[{wr_ch,wptr}] <= din; exp_ch increments.
  - If wr_ch==CHANNELS-1: wptr increments mod DEPTH, fill increments saturating at DEPTH-1, exp_ch wraps to 0, and frame_done pulses next cycle.
- Write, wr_ch!=exp_ch: seq_err pulses next cycle.
  - If wr_ch==0, the partial frame is abandoned and this sample is written as channel 0; exp_ch <= 1.
  - Otherwise the sample is dropped and exp_ch <= 0.
  - wptr and fill are unchanged in both cases. Abandoned frame data is overwritten later, never exposed.
- Read, rd_en=1:
  - Address = {rd_ch, (wptr-1-rd_delay) mod DEPTH}, using pre-edge wptr.
  - Miss when rd_delay ≥ fill (pre-edge); a miss forces dout=0 and dout_miss=1.
- The uncommitted frame slot (wptr) is never addressable, because fill ≤ DEPTH-1. A same-cycle read and write therefore never hit the same word; no bypass is needed.
- flush: wptr, exp_ch and fill <= 0. Memory contents are untouched. Reads already in the pipeline complete with their issue-time miss status. A write in the flush cycle is discarded.
- A frame commit and a read in the same cycle: the read sees pre-commit wptr/fill.

## Timing
- Reset values: dout=0, dout_valid=0, dout_miss=0, frame_done=0, seq_err=0, fill=0; wptr=0, exp_ch=0.
- Read latency 2: rd_en at edge t registers the address and miss flag; the RAM read registers at t+1; dout/dout_valid/dout_miss are valid after edge t+2.
  - Fully pipelined: one read per cycle, back-to-back, no stall.
  - dout holds its last value while dout_valid=0.
- Write: the word is written at the edge where wr_en is sampled.
  - The sample is readable by a read issued the cycle after its frame commits.
  - fill is updated at the commit edge.
- frame_done and seq_err are registered: high for exactly the cycle after the triggering write.
- Reset is asserted asynchronously and released synchronously by the integrator. Reset mid-read clears the pipeline; no dout_valid emerges for in-flight reads.

## Test plan
Bench parameters: WIDTH=16, DEPTH=8, CHANNELS=4.

1. Reset then read: rd_en with rd_ch=0, rd_delay=0 → 2 cycles later dout_valid=1, dout_miss=1, dout=0x0000; fill=0.
2. Write frames f=0..2, sample = 16'h{f,ch} e.g. 0x0102 → frame_done pulses three times, fill=3. Read ch2 delay0 → 0x0202; ch1 delay2 → 0x0001; ch0 delay3 → miss.
3. Write 12 frames → fill saturates at 7. Reads ch3 delay0..6 on consecutive cycles → 0x0B03 down to 0x0503, back-to-back valid, no miss. Delay 7 → miss.
4. Sequence error:
   - wr_ch 0,1,3 → seq_err at the ch3 write; the next ch0..3 frame commits normally with fill +1 only.
   - wr_ch 0,1,0,1,2,3 → seq_err on the second 0; the frame then commits with the second ch0 data.
5. Read issued in the same cycle as a ch3 commit, delay0 → returns the previous frame. flush during an active stream → fill=0 next cycle, an in-flight read completes with its pre-flush data, and a subsequent delay0 read misses.
6. Assert reset with two reads in flight → no dout_valid after reset release, and all outputs at reset values.
